// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus-v core.
// Holds the fetch-stage FSM encoding and the reset-time instruction/PC values.
package kamus_pkg;

  typedef enum logic [1:0] {
    PC_ST = 2'b00,
    J_ST  = 2'b01,
    B_ST  = 2'b10
  } instr_addr_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/kamus_next_pc.sv
// Combinational next-PC helper for the fetch stage.
// Decides whether execute redirects fetch and forms the aligned target and pc+4.
module kamus_next_pc
  import kamus_pkg::*;
(
  input  logic              redirect_valid,
  input  instr_addr_state_t addr_state,
  input  logic              branch_taken,
  input  logic [31:0]       target_addr,
  input  logic [31:0]       pc,
  output logic              redirect,
  output logic [31:0]       target_aligned,
  output logic [31:0]       pc_plus4
);

  // PC_ST never redirects; a branch only redirects when it is taken.
  assign redirect       = redirect_valid &&
                          ((addr_state == J_ST) || ((addr_state == B_ST) && branch_taken));
  assign target_aligned = word_align(target_addr);
  assign pc_plus4       = pc + 32'd4;

endmodule

// File: rtl/kamus_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, valid/ready to decode,
// redirect on jumps/taken branches with wrong-path response dropping.
module kamus_fetch_unit
  import kamus_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  instr_addr_state_t instr_addr_state_i,
  input  logic              redirect_valid_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       target_addr_i,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       instr_pc_o,
  output logic              flush_o
);

  fetch_state_t state_r, state_n_s;
  logic [31:0]  pc_r, pc_n_s;
  logic [31:0]  pc_target_r, pc_target_n_s;
  logic [31:0]  instr_r, instr_n_s;
  logic [31:0]  instr_pc_r, instr_pc_n_s;
  logic         drop_r, drop_n_s;
  logic         redirect_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_plus4_s;

  kamus_next_pc u_next_pc (
    .redirect_valid (redirect_valid_i),
    .addr_state     (instr_addr_state_i),
    .branch_taken   (branch_taken_i),
    .target_addr    (target_addr_i),
    .pc             (pc_r),
    .redirect       (redirect_s),
    .target_aligned (target_s),
    .pc_plus4       (pc_plus4_s)
  );

  assign flush_o       = redirect_s & ~rst_i;
  assign imem_req_o    = (state_r == REQ);
  assign imem_addr_o   = pc_r;
  assign instr_valid_o = (state_r == HOLD);
  assign instr_o       = instr_r;
  assign instr_pc_o    = instr_pc_r;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_n_s     = state_r;
    pc_n_s        = pc_r;
    pc_target_n_s = pc_target_r;
    drop_n_s      = drop_r;
    instr_n_s     = instr_r;
    instr_pc_n_s  = instr_pc_r;
    case (state_r)
      IDLE: begin
        state_n_s = REQ;
        if (redirect_s) begin
          pc_n_s = target_s;
        end else begin
          pc_n_s = pc_r;
        end
      end
      REQ: begin
        // The request address must not move before grant, so the target is parked.
        if (redirect_s) begin
          drop_n_s      = 1'b1;
          pc_target_n_s = target_s;
        end else begin
          drop_n_s      = drop_r;
        end
        if (imem_gnt_i) begin
          state_n_s = WAIT;
        end else begin
          state_n_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_r || redirect_s) begin
            drop_n_s  = 1'b0;
            pc_n_s    = redirect_s ? target_s : pc_target_r;
            state_n_s = REQ;
          end else begin
            instr_n_s    = imem_rdata_i;
            instr_pc_n_s = pc_r;
            state_n_s    = HOLD;
          end
        end else if (redirect_s) begin
          drop_n_s      = 1'b1;
          pc_target_n_s = target_s;
        end else begin
          state_n_s = WAIT;
        end
      end
      HOLD: begin
        // Redirect beats a simultaneous accept; the decoder kills that word via flush.
        if (redirect_s) begin
          pc_n_s    = target_s;
          state_n_s = REQ;
        end else if (instr_ready_i) begin
          pc_n_s    = pc_plus4_s;
          state_n_s = REQ;
        end else begin
          state_n_s = HOLD;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      pc_r        <= RESET_VECTOR;
      pc_target_r <= RESET_VECTOR;
      drop_r      <= 1'b0;
      instr_r     <= NOP_INSTR;
      instr_pc_r  <= RESET_VECTOR;
    end else begin
      state_r     <= state_n_s;
      pc_r        <= pc_n_s;
      pc_target_r <= pc_target_n_s;
      drop_r      <= drop_n_s;
      instr_r     <= instr_n_s;
      instr_pc_r  <= instr_pc_n_s;
    end
  end

endmodule
